// File: rtl/gamepad_pmod_tx.sv
// Gamepad Pmod link serializer: snapshots two 12-bit controller states and
// shifts them out MSB first on pmod_data/pmod_clk, then strobes pmod_latch.
module gamepad_pmod_tx #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] buttons1,
  input  logic        present1,
  input  logic [11:0] buttons2,
  input  logic        present2,
  output logic        pmod_data,
  output logic        pmod_clk,
  output logic        pmod_latch,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [22:0] shreg;
  logic [23:0] frame;
  logic        div_last;

  // An absent controller reads as all buttons pressed, which the receiver decodes as unplugged.
  assign frame    = {present1 ? buttons1 : 12'hFFF, present2 ? buttons2 : 12'hFFF};
  assign div_last = (div_cnt == DIV_LAST);

  // pmod_data holds the current bit; shreg holds only the bits still to be sent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pmod_data  <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOW;
            busy      <= 1'b1;
            pmod_data <= frame[23];
            shreg     <= frame[22:0];
            bit_cnt   <= '0;
            div_cnt   <= '0;
          end
        end
        LOW: begin
          if (div_last) begin
            state    <= HIGH;
            pmod_clk <= 1'b1;
            div_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (div_last) begin
            div_cnt  <= '0;
            pmod_clk <= 1'b0;
            if (bit_cnt == 5'd23) begin
              state      <= LATCH;
              pmod_latch <= 1'b1;
              pmod_data  <= 1'b0;
            end else begin
              state     <= LOW;
              bit_cnt   <= bit_cnt + 5'd1;
              pmod_data <= shreg[22];
              shreg     <= {shreg[21:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        LATCH: begin
          if (div_last) begin
            state      <= IDLE;
            div_cnt    <= '0;
            pmod_latch <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Bench for gamepad_pmod_tx: two instances (CLK_DIV 8 and 2) checked every
// cycle against a frame-timeline model, plus hand-computed frame checks.
module tb_gamepad_pmod_tx;

  localparam int D0 = 8;
  localparam int D1 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b1;
  logic [11:0] buttons1 = '0;
  logic        present1 = 1'b0;
  logic [11:0] buttons2 = '0;
  logic        present2 = 1'b0;

  logic data0, sclk0, latch0, busy0, done0;
  logic data1, sclk1, latch1, busy1, done1;

  gamepad_pmod_tx #(.CLK_DIV(D0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .buttons1(buttons1), .present1(present1),
    .buttons2(buttons2), .present2(present2),
    .pmod_data(data0), .pmod_clk(sclk0), .pmod_latch(latch0),
    .busy(busy0), .done(done0)
  );

  gamepad_pmod_tx #(.CLK_DIV(D1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .buttons1(buttons1), .present1(present1),
    .buttons2(buttons2), .present2(present2),
    .pmod_data(data1), .pmod_clk(sclk1), .pmod_latch(latch1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Model: a frame is a timeline t = 1 .. 49*D after acceptance.
  logic        m_act  [2] = '{1'b0, 1'b0};
  int          m_t    [2] = '{0, 0};
  logic [23:0] m_w    [2] = '{24'h0, 24'h0};
  logic        m_done [2] = '{1'b0, 1'b0};

  function automatic int divOf(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_done[i] = 1'b0;
      end else if (m_act[i]) begin
        if (m_t[i] == 49 * divOf(i)) begin
          m_act[i] = 1'b0; m_t[i] = 0; m_done[i] = 1'b1;
        end else begin
          m_t[i] = m_t[i] + 1; m_done[i] = 1'b0;
        end
      end else begin
        m_done[i] = 1'b0;
        if (start) begin
          m_act[i] = 1'b1; m_t[i] = 1;
          m_w[i] = {present1 ? buttons1 : 12'hFFF, present2 ? buttons2 : 12'hFFF};
        end
      end
    end
  end

  // Packed as {data, clk, latch, busy, done}.
  function automatic logic [4:0] expected(input int i);
    int d;
    logic [4:0] e;
    d = divOf(i);
    e = '0;
    if (m_act[i]) begin
      e[1] = 1'b1;
      if (m_t[i] <= 48 * d) begin
        e[3] = (((m_t[i] - 1) % (2 * d)) >= d);
        e[4] = m_w[i][23 - (m_t[i] - 1) / (2 * d)];
      end else begin
        e[2] = 1'b1;
      end
    end
    e[0] = m_done[i];
    return e;
  endfunction

  logic        checking = 1'b0;
  logic        btb_mode = 1'b0;
  int          cyc = 0;
  int          busy_cnt0 = 0, latch_cnt0 = 0, done_cnt0 = 0, rises0 = 0;
  int          bad_tog0 = 0, bad_tog1 = 0, intervals = 0, last_done1 = 0;
  logic        last_valid = 1'b0;
  logic [23:0] cap0 = '0;
  logic        pclk0 = 1'b0, pdat0 = 1'b0, pclk1 = 1'b0, pdat1 = 1'b0;

  // Compare process: every cycle against the model, plus frame bookkeeping.
  always @(negedge clk) begin
    cyc++;
    if (checking) begin
      checkOutput("out0", {27'd0, data0, sclk0, latch0, busy0, done0}, {27'd0, expected(0)});
      checkOutput("out1", {27'd0, data1, sclk1, latch1, busy1, done1}, {27'd0, expected(1)});
    end
    if (busy0) busy_cnt0++;
    if (latch0) latch_cnt0++;
    if (done0) done_cnt0++;
    if (sclk0 && !pclk0) begin
      rises0++;
      cap0 = {cap0[22:0], data0};
      if (data0 !== pdat0) bad_tog0++;
    end
    if (sclk1 && !pclk1 && data1 !== pdat1) bad_tog1++;
    if (!btb_mode) last_valid = 1'b0;
    else if (done1) begin
      if (last_valid) begin
        checkOutput("btb_interval", cyc - last_done1, 99);
        intervals++;
      end
      last_done1 = cyc;
      last_valid = 1'b1;
    end
    pclk0 = sclk0; pdat0 = data0; pclk1 = sclk1; pdat1 = data1;
  end

  task automatic applyStimulus(input logic p1, input logic [11:0] b1, input logic p2, input logic [11:0] b2);
    @(negedge clk);
    present1 = p1; buttons1 = b1; present2 = p2; buttons2 = b2;
  endtask

  task automatic waitDone0(input string name);
    int n;
    n = 0;
    while (!done0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) checkOutput({name, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  task automatic runFrame(input string name, input logic [23:0] want);
    int b0, l0, d0, r0, n;
    b0 = busy_cnt0; l0 = latch_cnt0; d0 = done_cnt0; r0 = rises0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!sclk0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_first_rise"}, n, 9);
    waitDone0(name);
    checkOutput({name, "_word"}, {8'd0, cap0}, {8'd0, want});
    checkOutput({name, "_rises"}, rises0 - r0, 24);
    checkOutput({name, "_busy_cycles"}, busy_cnt0 - b0, 392);
    checkOutput({name, "_latch_cycles"}, latch_cnt0 - l0, 8);
    checkOutput({name, "_done_pulses"}, done_cnt0 - d0, 1);
  endtask

  initial begin
    int d0, l0;
    // Reset held with start asserted.
    @(negedge clk);
    checking = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_out0", {27'd0, data0, sclk0, latch0, busy0, done0}, 0);
    checkOutput("reset_out1", {27'd0, data1, sclk1, latch1, busy1, done1}, 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);

    applyStimulus(1'b1, 12'hA5C, 1'b1, 12'h3F0);
    runFrame("frame_a5c3f0", 24'hA5C3F0);
    applyStimulus(1'b0, 12'h000, 1'b0, 12'h000);
    runFrame("frame_absent", 24'hFFFFFF);
    applyStimulus(1'b1, 12'h000, 1'b0, 12'h000);
    runFrame("frame_c1_zero", 24'h000FFF);

    // Snapshot: inputs and start change mid-frame.
    applyStimulus(1'b1, 12'h001, 1'b0, 12'h000);
    d0 = done_cnt0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    buttons1 = 12'h800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone0("snapshot");
    checkOutput("snapshot_word", {8'd0, cap0}, 32'h00001FFF);
    checkOutput("snapshot_done", done_cnt0 - d0, 1);
    repeat (500) @(negedge clk);
    checkOutput("snapshot_no_requeue", done_cnt0 - d0, 1);

    // Back-to-back frames with start held.
    btb_mode = 1'b1;
    start = 1'b1;
    repeat (1000) @(negedge clk);
    start = 1'b0;
    btb_mode = 1'b0;
    checkOutput("btb_interval_count", intervals >= 8, 1);
    repeat (500) @(negedge clk);
    checkOutput("rise_data_stable0", bad_tog0, 0);
    checkOutput("rise_data_stable1", bad_tog1, 0);

    // Reset mid-frame aborts without latching.
    applyStimulus(1'b1, 12'h0F0, 1'b1, 12'h00F);
    d0 = done_cnt0; l0 = latch_cnt0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_out0", {27'd0, data0, sclk0, latch0, busy0, done0}, 0);
    repeat (500) @(negedge clk);
    checkOutput("abort_no_latch", latch_cnt0 - l0, 0);
    checkOutput("abort_no_done", done_cnt0 - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gamepad_pmod_tx.md
# gamepad_pmod_tx

Serializer for the gamepad Pmod link. It drives the data, clock and latch lines that the in-design gamepad receiver samples. It snapshots the button states of up to two controllers and shifts them out as one 24-bit frame, then pulses the latch. It is used as the controller-side emulator in the game testbench and on the FPGA bring-up board, where button states come from local switches.

## Interface
Parameters:
- CLK_DIV, default 8: system clocks per half period of pmod_clk. Legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  frame request; sampled only while busy=0.
- buttons1  in  12  controller 1 buttons, 1 = pressed, order {b,y,select,start,up,down,left,right,a,x,l,r} as [11:0].
- present1  in  1  controller 1 connected.
- buttons2  in  12  controller 2 buttons, same order.
- present2  in  1  controller 2 connected.
- pmod_data  out  1  serial data, MSB first.
- pmod_clk  out  1  shift clock; the receiver samples pmod_data on its rising edge.
- pmod_latch  out  1  frame-complete strobe.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse after the latch phase ends.

## Operation
- Frame word W[23:0] = {C1, C2}:
  - C1 = present1 ? buttons1 : 12'hFFF.
  - C2 = present2 ? buttons2 : 12'hFFF.
  - All-ones means "not present" to the receiver. W is captured into a 24-bit shift register at start acceptance. Input changes after capture do not affect the frame in flight.
- FSM states:
  - IDLE: pmod_clk=0, pmod_latch=0, busy=0. start=1 → load W, bit counter=0, div counter=0, go to LOW.
  - LOW: pmod_clk=0, pmod_data=W[23-bit]. After CLK_DIV cycles → HIGH.
  - HIGH: pmod_clk=1, pmod_data held. After CLK_DIV cycles:
    - if bit=23 → LATCH;
    - otherwise bit+1, shift left, → LOW.
  - LATCH: pmod_clk=0, pmod_latch=1, pmod_data=0. After CLK_DIV cycles → IDLE with done=1 for exactly one cycle.
- pmod_data changes only on entry to LOW, i.e. coincident with a pmod_clk falling edge or frame start. It is never changed in the same cycle pmod_clk rises.
- Div counter: 8 bits, counts 0..CLK_DIV-1, clears on every state change. Bit counter: 5 bits, range 0..23.
- start while busy=1 is ignored; it is not queued. start held high continuously yields back-to-back frames with exactly one IDLE cycle between them; done is asserted in that cycle.
- Reset asserted mid-frame aborts immediately. The partial frame is not latched.

## Timing
- Reset values (cycle after rst_n=0 sampled): pmod_data=0, pmod_clk=0, pmod_latch=0, busy=0, done=0, FSM=IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Frame timeline, with start sampled at edge N:
  - busy=1 and first LOW from N+1.
  - First pmod_clk rise at N+1+CLK_DIV.
  - LATCH from N+1+48·CLK_DIV, lasting CLK_DIV cycles.
  - done=1 and busy=0 at N+1+49·CLK_DIV.
- busy is high for exactly 49·CLK_DIV cycles per frame.
- pmod_clk period is 2·CLK_DIV cycles at 50% duty. The default gives 16 clk cycles per bit, which gives the receiver's 2-flop synchronizer margin.

## Test plan
- Reset: hold rst_n=0 with start=1 for 3 cycles → all outputs 0. With CLK_DIV=8, first pmod_clk rise occurs 9 cycles after the first start-sampled edge following reset release.
- Single frame, CLK_DIV=8: present1=1, buttons1=12'hA5C, present2=1, buttons2=12'h3F0, start pulse 1 cycle → bits captured at the 24 pmod_clk rises equal 24'hA5C3F0 MSB first. latch high for 8 cycles, done pulse 1 cycle, busy high for 392 cycles.
- Absent controllers: present1=0, buttons1=12'h000, present2=0 → frame 24'hFFFFFF. Present1=1 with buttons1=0, present2=0 → 24'h000FFF.
- Snapshot/ignore: start at cycle 0 with buttons1=12'h001; change buttons1 to 12'h800 and pulse start at cycle 100 → single frame 24'h001xxx, no second frame, done pulses once.
- Back-to-back: start held high for 1000 cycles with CLK_DIV=2 → frames every 99 cycles, exactly one IDLE cycle with done=1 between frames. pmod_data never toggles in a cycle where pmod_clk rises.
- Loopback: connect to the gamepad receiver with CLK_DIV=8, press up on controller 1 only → receiver up=1, all other buttons 0, is_present=1 after the first latch.
